// File: rtl/alu_pkg.sv
// Shared opcodes, flag indices and FSM encoding for the ALU sequencer.
// Optional counters in alu_seq_ctrl are enabled by ALU_SEQ_PERF_EN.
package alu_pkg;

    localparam int ALU_WIDTH     = 20;
    localparam int ALU_SHW       = 5;
    localparam int ALU_MAX_SHIFT = 20;

    localparam logic [3:0] OP_NOT  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_LDSR = 4'd8;
    localparam logic [3:0] OP_XSR  = 4'd9;
    localparam logic [3:0] OP_NOP  = 4'd10;
    localparam logic [3:0] OP_TRAP = 4'd15;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_S = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_TRAP  = 3'd4
    } state_t;

    function automatic logic is_logic(input logic [3:0] o);
        return (o == OP_NOT) || (o == OP_AND) ||
               (o == OP_OR)  || (o == OP_XOR);
    endfunction

    function automatic logic is_shift(input logic [3:0] o);
        return (o == OP_SHR) || (o == OP_SHL);
    endfunction

    function automatic logic is_shrot(input logic [3:0] o);
        return is_shift(o) || (o == OP_ROR) || (o == OP_ROL);
    endfunction

endpackage

// File: rtl/alu_step.sv
// Combinational single-step ALU: logic ops or one 1-bit shift/rotate.
// Other opcodes pass operand A through unchanged.
module alu_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_cout
);

    always_comb begin
        o_y    = i_a;
        o_cout = 1'b0;
        case (i_op)
            OP_NOT: o_y = ~i_a;
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_XOR: o_y = i_a ^ i_b;
            OP_SHR: begin
                o_y    = {1'b0, i_a[WIDTH-1:1]};
                o_cout = i_a[0];
            end
            OP_SHL: begin
                o_y    = {i_a[WIDTH-2:0], 1'b0};
                o_cout = i_a[WIDTH-1];
            end
            OP_ROR: begin
                o_y    = {i_a[0], i_a[WIDTH-1:1]};
                o_cout = i_a[0];
            end
            OP_ROL: begin
                o_y    = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
                o_cout = i_a[WIDTH-1];
            end
            default: begin
                o_y    = i_a;
                o_cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Execute-stage sequencer: handshake, iterated shifts, Z/S/C status and trap.
// Define ALU_SEQ_PERF_EN to add op_count/busy_cycles counters.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int SHW       = ALU_SHW,
    parameter int MAX_SHIFT = ALU_MAX_SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             trap,
    output logic             busy
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0]      op_count,
    output logic [31:0]      busy_cycles
`endif
);

    localparam logic [SHW-1:0] LP_MAX = SHW'(MAX_SHIFT);

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_b;
    logic [SHW-1:0]   r_cnt;

    logic [SHW-1:0]   w_shamt_c;
    logic [WIDTH-1:0] w_y;
    logic             w_cout;
    logic             w_zero;

    assign w_shamt_c = (shamt > LP_MAX) ? LP_MAX : shamt;
    assign w_zero    = (w_y == '0);

    alu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_op   (r_op),
        .i_a    (r_work),
        .i_b    (r_b),
        .o_y    (w_y),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_work    <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            result    <= '0;
            flags     <= '0;
            res_valid <= 1'b0;
            trap      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op      <= op;
                        r_work    <= a;
                        r_b       <= b;
                        r_cnt     <= w_shamt_c;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (op == OP_TRAP) begin
                            r_state <= ST_TRAP;
                            trap    <= 1'b1;
                        end else if (is_shrot(op) && (w_shamt_c != '0)) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_state   <= ST_DONE;
                    res_valid <= 1'b1;
                    if (is_logic(r_op)) begin
                        result       <= w_y;
                        flags[FLG_S] <= w_y[WIDTH-1];
                        flags[FLG_Z] <= w_zero;
                        flags[FLG_C] <= 1'b0;
                    end else if (r_op == OP_LDSR) begin
                        result <= r_work;
                        flags  <= r_work[2:0];
                    end else if (r_op == OP_XSR) begin
                        result <= r_work;
                        flags  <= flags ^ r_work[2:0];
                    end else begin
                        // zero-count shifts, NOP and undefined opcodes
                        result <= r_work;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_y;
                    r_cnt  <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_state      <= ST_DONE;
                        res_valid    <= 1'b1;
                        result       <= w_y;
                        flags[FLG_S] <= w_y[WIDTH-1];
                        flags[FLG_Z] <= w_zero;
                        if (is_shift(r_op)) begin
                            flags[FLG_C] <= w_cout;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state   <= ST_IDLE;
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                ST_TRAP: begin
                    trap      <= 1'b1;
                    req_ready <= 1'b0;
                    res_valid <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count    <= '0;
            busy_cycles <= '0;
        end else begin
            if (res_valid && res_ready) begin
                op_count <= op_count + 32'd1;
            end
            if (busy) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with an arithmetic reference model.
// Model computes whole shifts/rotates at once and tracks expected latency.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [3:0]  op = '0;
    logic [19:0] a = '0;
    logic [19:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        req_ready;
    logic        res_valid;
    logic [19:0] result;
    logic [2:0]  flags;
    logic        trap;
    logic        busy;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] op_count;
    logic [31:0] busy_cycles;
`endif

    alu_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .shamt       (shamt),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .flags       (flags),
        .trap        (trap),
        .busy        (busy)
`ifdef ALU_SEQ_PERF_EN
        ,
        .op_count    (op_count),
        .busy_cycles (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [19:0] m_res = '0;
    logic [2:0]  m_flags = '0;
    logic        m_pending = 1'b0;
    logic        m_trap = 1'b0;
    logic [19:0] o_res;
    logic [2:0]  o_flg;
    int          o_lat;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [19:0] ia,
                                  input logic [19:0] ib, input logic [4:0] sh,
                                  input logic [2:0] fin,
                                  output logic [19:0] r, output logic [2:0] f,
                                  output int lat);
        int n;
        int k;
        logic [39:0] x;
        logic [39:0] y;
        n = (sh > 5'd20) ? 20 : int'(sh);
        k = n % 20;
        x = {20'b0, ia};
        r = ia;
        f = fin;
        lat = 2;
        case (o)
            4'd0: r = ~ia;
            4'd1: r = ia & ib;
            4'd2: r = ia | ib;
            4'd3: r = ia ^ ib;
            4'd4: if (n > 0) begin
                y = x >> n;
                r = y[19:0];
                f[0] = x[n-1];
            end
            4'd5: if (n > 0) begin
                y = x << n;
                r = y[19:0];
                f[0] = y[20];
            end
            4'd6: if (n > 0) begin
                y = (x >> k) | (x << (20 - k));
                r = y[19:0];
            end
            4'd7: if (n > 0) begin
                y = (x << k) | (x >> (20 - k));
                r = y[19:0];
            end
            4'd8: f = ia[2:0];
            4'd9: f = fin ^ ia[2:0];
            default: r = ia;
        endcase
        if (o <= 4'd3) begin
            f = {r[19], (r == 20'd0), 1'b0};
        end else if (o <= 4'd7 && n > 0) begin
            f[2] = r[19];
            f[1] = (r == 20'd0);
            lat = n + 1;
        end
    endfunction

    // Every cycle: trap must match the model, and a result may appear only
    // while one is owed, with the model's value and flags.
    always @(negedge clk) begin
        if (!rst) begin
            chk("trap_state", {31'd0, trap}, {31'd0, m_trap});
            if (!m_pending) begin
                chk("no_spurious_valid", {31'd0, res_valid}, 32'd0);
            end else if (res_valid) begin
                chk("cmp_result", {12'd0, result}, {12'd0, m_res});
                chk("cmp_flags", {29'd0, flags}, {29'd0, m_flags});
                chk("cmp_ready_low", {31'd0, req_ready}, 32'd0);
                chk("cmp_busy", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [19:0] ia,
                         input logic [19:0] ib, input logic [4:0] sh,
                         input int hold);
        int lat;
        int cyc;
        logic [19:0] r;
        logic [2:0] f;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        op = o;
        a = ia;
        b = ib;
        shamt = sh;
        res_ready = (hold == 0);
        model(o, ia, ib, sh, m_flags, r, f, lat);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        m_res = r;
        m_flags = f;
        m_pending = 1'b1;
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_ready_low", {31'd0, req_ready}, 32'd0);
        cyc = 1;
        while (!res_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", cyc, lat);
        o_res = result;
        o_flg = flags;
        o_lat = cyc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 2) begin
                req_valid = 1'b1;
                op = OP_AND;
                a = 20'hFFFFF;
                chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            chk("bp_valid_held", {31'd0, res_valid}, 32'd1);
            chk("bp_result_held", {12'd0, result}, {12'd0, o_res});
        end
        if (hold > 0) begin
            @(negedge clk);
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        m_pending = 1'b0;
        chk("hs_valid_low", {31'd0, res_valid}, 32'd0);
        chk("hs_ready_high", {31'd0, req_ready}, 32'd1);
        chk("hs_busy_low", {31'd0, busy}, 32'd0);
    endtask

    task automatic pin(input string name, input logic [19:0] er,
                       input logic [2:0] ef);
        chk({name, "_res"}, {12'd0, o_res}, {12'd0, er});
        chk({name, "_flags"}, {29'd0, o_flg}, {29'd0, ef});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", {12'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, flags}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        issue(OP_AND, 20'hF0F0F, 20'h0FFFF, 5'd0, 0);
        pin("and", 20'h00F0F, 3'b000);
        chk("and_lat", o_lat, 32'd2);
        issue(OP_SHL, 20'h80001, 20'h0, 5'd3, 0);
        pin("shl3", 20'h00008, 3'b000);
        chk("shl3_lat", o_lat, 32'd4);
        issue(OP_SHL, 20'h20000, 20'h0, 5'd3, 0);
        pin("shl3b", 20'h00000, 3'b011);
        issue(OP_ROR, 20'h00001, 20'h0, 5'd1, 0);
        pin("ror1", 20'h80000, 3'b101);
        issue(OP_ROR, 20'h12345, 20'h0, 5'd25, 0);
        pin("ror25", 20'h12345, 3'b001);
        chk("ror25_lat", o_lat, 32'd21);
        issue(OP_LDSR, 20'h00005, 20'h0, 5'd0, 0);
        pin("ldsr", 20'h00005, 3'b101);
        issue(OP_XSR, 20'h00007, 20'h0, 5'd0, 0);
        pin("xsr", 20'h00007, 3'b010);
        issue(OP_OR, 20'h12340, 20'h00005, 5'd0, 0);
        pin("or", 20'h12345, 3'b000);
        issue(OP_XOR, 20'hA5A5A, 20'hA5A5A, 5'd0, 0);
        pin("xor", 20'h00000, 3'b010);
        issue(OP_NOT, 20'h0000F, 20'h0, 5'd0, 0);
        pin("not", 20'hFFFF0, 3'b100);
        issue(OP_SHR, 20'h80000, 20'h0, 5'd20, 0);
        pin("shr20", 20'h00000, 3'b011);
        issue(OP_SHL, 20'h00001, 20'h0, 5'd31, 0);
        pin("shl31", 20'h00000, 3'b011);
        issue(OP_ROL, 20'h80000, 20'h0, 5'd1, 0);
        pin("rol1", 20'h00001, 3'b001);
        issue(OP_SHR, 20'h55555, 20'h0, 5'd0, 0);
        pin("shr0", 20'h55555, 3'b001);
        chk("shr0_lat", o_lat, 32'd2);
        issue(OP_NOP, 20'hABCDE, 20'h0, 5'd0, 0);
        pin("nop", 20'hABCDE, 3'b001);
        issue(4'd11, 20'h13579, 20'h0, 5'd0, 0);
        pin("undef", 20'h13579, 3'b001);
        issue(OP_XOR, 20'h0F0F0, 20'hFFFFF, 5'd0, 5);
        pin("bp_xor", 20'hF0F0F, 3'b100);

        // Reset in the middle of a 10-step shift
        @(negedge clk);
        req_valid = 1'b1;
        op = OP_SHR;
        a = 20'hFFFFF;
        shamt = 5'd10;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_flags = 3'b000;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_flags", {29'd0, flags}, 32'd0);
        chk("midrst_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        res_ready = 1'b0;
        issue(OP_AND, 20'hFFFFF, 20'h00F00, 5'd0, 0);
        pin("post_rst", 20'h00F00, 3'b000);

        // Trap entry, stickiness and exit by reset
        @(negedge clk);
        req_valid = 1'b1;
        op = OP_TRAP;
        @(posedge clk);
        #1;
        m_trap = 1'b1;
        chk("trap_set", {31'd0, trap}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            op = 4'(i % 10);
            chk("trap_ready_low", {31'd0, req_ready}, 32'd0);
            chk("trap_busy", {31'd0, busy}, 32'd1);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_trap = 1'b0;
        chk("trap_cleared", {31'd0, trap}, 32'd0);
        chk("trap_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Execute-stage controller that sequences the 20-bit ALU datapath: NOT, AND, OR, XOR, single-bit shift and rotate units, and the status register ops.
- Accepts one operation at a time over a valid/ready handshake.
- Iterates the 1-bit shift/rotate units for multi-bit shift amounts.
- Owns the Z/S/C status register and the trap state.
- Sits between instruction decode and register writeback.

Parameters:
- WIDTH, 20, datapath width (a, b, result)
- SHW, 5, shift-amount width
- MAX_SHIFT, 20, shift amounts above this clamp to MAX_SHIFT

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  operation offered
- req_ready  out  1  controller can accept
- op  in  4  opcode (package constants)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- shamt  in  SHW  shift/rotate count
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- flags  out  3  status register {S,Z,C}
- trap  out  1  trap mode entered (sticky)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at clk edge): state=IDLE; result=0, flags=0, res_valid=0, trap=0, busy=0, req_ready=1. Reset mid-shift or mid-DONE aborts; no res_valid is issued.
- States: IDLE, EXEC, SHIFT, DONE, TRAP.
- IDLE: req_ready=1. Accept on req_valid&req_ready; latch op/a/b/clamped shamt. Next state: TRAP if op=TRAP; SHIFT if op is SHR/SHL/ROR/ROL and shamt>0; EXEC otherwise.
- EXEC (1 cycle): compute result and flags, then DONE. Latency for a 1-cycle op is acceptance edge to res_valid high on the following edge, i.e. 2 clocks from acceptance.
- Logic ops: result = op(a,b), with NOT using a. C=0, Z=(result==0), S=result[19].
- Shift/rotate with shamt=0: result=a, flags are not updated.
- SHIFT: one 1-bit step per cycle; the internal counter loads the clamped shamt and decrements to 0, then DONE. N steps take N cycles in SHIFT.
  - SHR/SHL: zero fill; C = last bit shifted out.
  - ROR/ROL: C is unchanged.
  - Z and S are taken from the final value.
  - shamt≥20 on a shift gives result 0 and Z=1; C = a[19] for SHR and a[0] for SHL.
- LDSR: flags ← a[2:0]; result=a.
- XSR: flags ← flags ^ a[2:0]; result=a.
- NOP and undefined opcodes: result=a, flags unchanged.
- DONE: res_valid=1; result and flags stable. Leave to IDLE on res_ready. A new request is accepted no earlier than the cycle after the handshake; there is no overlap.
- TRAP: trap=1, req_ready=0, res_valid=0. Exit only by rst.
- req_ready=0 in every state except IDLE.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- When defined: adds output op_count (32 bits), incremented on each completed result handshake (res_valid&res_ready). Also adds output busy_cycles (32 bits), incremented on every cycle with busy=1. Both are cleared by rst and wrap at 2^32.
- When undefined: the ports and counters are absent.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: NOT=0, AND=1, OR=2, XOR=3, SHR=4, SHL=5, ROR=6, ROL=7, LDSR=8, XSR=9, NOP=10, TRAP=15
  - flag bit indices: C=0, Z=1, S=2
  - WIDTH default
  - state encoding
- Sub-module alu_step: combinational single-step unit (logic op or 1-bit shift/rotate with carry-out). It is instantiated once and fed by the controller's working register.

Test Plan:
- AND a=0xF0F0F, b=0x0FFFF, res_ready=1 → res_valid 2 clocks after acceptance, result=0x00F0F, flags=000.
- SHL a=0x80001, shamt=3 → 3 cycles in SHIFT, result=0x00008, C=0, Z=0, S=0. Repeat with a=0x20000 → result=0x00000, C=1, Z=1.
- ROR a=0x00001, shamt=1 with prior flags C=1 → result=0x80000, S=1, C stays 1. Then shamt=25 (clamped to 20) on a=0x12345 → result=0x12345.
- LDSR a=0x00005 → flags=101. Then XSR a=0x00007 → flags=010.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → result/res_valid stable, req_ready=0, a req_valid pulse is ignored. Assert rst during a 10-step SHIFT → next cycle IDLE, flags=0, no res_valid.
- TRAP op → trap=1 and sticky. req_ready stays 0 over 20 cycles of req_valid. rst clears trap.
